// File: rtl/hw_dec_pkg.sv
// Shared types and helpers for the registered priority decoder.
// Sized for the widest legal index (8 bits -> 256 lines); callers truncate.
package hw_dec_pkg;

  localparam int DEC_MAX_N = 8;
  localparam int DEC_MAX_W = 1 << DEC_MAX_N;

  typedef enum logic [1:0] {
    DEC_EMPTY,
    DEC_ONE,
    DEC_FULL
  } dec_state_t;

  // A set "none" flag stands in for the encoder's all-zero case.
  function automatic logic [DEC_MAX_W-1:0] onehot(input logic [DEC_MAX_N-1:0] idx,
                                                  input logic                 none);
    logic [DEC_MAX_W-1:0] vec;
    vec = '0;
    if (!none) vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/hw_dec_skid.sv
// Generic two-entry valid/ready buffer: output register plus skid register.
// Ready is registered from the next state, so it never depends on out_ready_i.
module hw_dec_skid
  import hw_dec_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  dec_state_t   state_q, state_d;
  logic         ready_q;
  logic [W-1:0] data_q, skid_q;
  logic         accept, xfer;

  assign accept = in_valid_i && ready_q;
  assign xfer   = out_valid_o && out_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DEC_EMPTY;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != DEC_FULL);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DEC_EMPTY: if (accept) state_d = DEC_ONE;
      DEC_ONE: begin
        if (accept && !xfer)      state_d = DEC_FULL;
        else if (!accept && xfer) state_d = DEC_EMPTY;
      end
      DEC_FULL: if (xfer) state_d = DEC_ONE;
      default: state_d = DEC_EMPTY;
    endcase
  end

  always_comb begin
    out_valid_o = (state_q != DEC_EMPTY);
    in_ready_o  = ready_q;
    out_data_o  = data_q;
  end

  // A new entry lands in the skid only when the output register is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      skid_q <= '0;
    end else begin
      case (state_q)
        DEC_EMPTY: if (accept) data_q <= in_data_i;
        DEC_ONE: begin
          if (accept && xfer) data_q <= in_data_i;
          else if (accept)    skid_q <= in_data_i;
        end
        DEC_FULL: if (xfer) data_q <= skid_q;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/hw_priority_decoder.sv
// Registered index-to-one-hot decoder with an optional sticky accumulate mask,
// streaming through a two-entry output buffer.
module hw_priority_decoder
  import hw_dec_pkg::*;
#(
  parameter int n = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [n-1:0]    in_idx,
  input  logic            in_none,
  input  logic            in_acc,
  input  logic            acc_clr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2**n-1:0] dec_out,
  output logic [2**n-1:0] acc_mask
);

  localparam int W = 2 ** n;

  logic                 accept;
  logic [DEC_MAX_N-1:0] idxExt;
  logic [W-1:0]         ohVec, maskNext, result;
  logic [W-1:0]         accMask_q, accMask_d;

  assign accept = in_valid && in_ready;
  assign idxExt = DEC_MAX_N'(in_idx);
  assign ohVec  = W'(onehot(idxExt, in_none));

  // A same-cycle clear wipes the old mask before the new index is merged in.
  always_comb begin
    maskNext  = (acc_clr ? '0 : accMask_q) | ohVec;
    result    = in_acc ? maskNext : ohVec;
    accMask_d = accMask_q;
    if (accept && in_acc) accMask_d = maskNext;
    else if (acc_clr)     accMask_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) accMask_q <= '0;
    else     accMask_q <= accMask_d;
  end

  assign acc_mask = accMask_q;

  hw_dec_skid #(
    .W(W)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (result),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (dec_out)
  );

endmodule

// File: tb/tb_hw_priority_decoder.sv
// Self-checking bench for hw_priority_decoder (n=3): directed scenarios then
// randomized traffic against a queue-based reference model.
module tb_hw_priority_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       inValid = 1'b0;
  logic       inReady;
  logic [2:0] inIdx = '0;
  logic       inNone = 1'b0;
  logic       inAcc = 1'b0;
  logic       accClr = 1'b0;
  logic       outValid;
  logic       outReady = 1'b0;
  logic [7:0] decOut;
  logic [7:0] accMask;

  int checks = 0;
  int errors = 0;

  logic [7:0] expQ[$];
  logic [7:0] modelMask = '0;
  logic       armed = 1'b0;

  always #5 clk = ~clk;

  hw_priority_decoder #(.n(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (inValid),
    .in_ready (inReady),
    .in_idx   (inIdx),
    .in_none  (inNone),
    .in_acc   (inAcc),
    .acc_clr  (accClr),
    .out_valid(outValid),
    .out_ready(outReady),
    .dec_out  (decOut),
    .acc_mask (accMask)
  );

  task automatic checkValue(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // Reference behaviour at one rising edge, from the bench's own inputs.
  task automatic modelEdge();
    logic       ready, acceptM, xferM;
    logic [7:0] oh, res;
    ready   = armed && (expQ.size() < 2);
    acceptM = inValid && ready;
    xferM   = (expQ.size() > 0) && outReady;
    oh      = inNone ? 8'h00 : (8'h01 << inIdx);
    res     = oh;
    if (acceptM && inAcc) begin
      modelMask = (accClr ? 8'h00 : modelMask) | oh;
      res       = modelMask;
    end else if (accClr) begin
      modelMask = 8'h00;
    end
    if (xferM) void'(expQ.pop_front());
    if (acceptM) expQ.push_back(res);
    armed = 1'b1;
  endtask

  task automatic checkOutput();
    checkValue("in_ready", {7'd0, inReady}, {7'd0, armed && (expQ.size() < 2)});
    checkValue("out_valid", {7'd0, outValid}, {7'd0, expQ.size() > 0});
    if (expQ.size() > 0) checkValue("dec_out", decOut, expQ[0]);
    checkValue("acc_mask", accMask, modelMask);
  endtask

  task automatic applyStimulus(input logic v, input int idx, input logic none,
                               input logic acc, input logic clr, input logic ordy);
    inValid  = v;
    inIdx    = 3'(idx);
    inNone   = none;
    inAcc    = acc;
    accClr   = clr;
    outReady = ordy;
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    // Reset state
    #1 rst = 1'b1;
    #1;
    checkValue("reset dec_out", decOut, 8'h00);
    checkValue("reset acc_mask", accMask, 8'h00);
    checkOutput();
    @(negedge clk);
    checkOutput();
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 1);

    // Plain stream with a ready consumer
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkValue("stream idx0", decOut, 8'h01);
    applyStimulus(1, 5, 0, 0, 0, 1);
    checkValue("stream idx5", decOut, 8'h20);
    applyStimulus(1, 7, 0, 0, 0, 1);
    checkValue("stream idx7", decOut, 8'h80);

    // No-request flag
    applyStimulus(1, 6, 1, 0, 0, 1);
    checkValue("none dec_out", decOut, 8'h00);

    // Accumulate sequence
    applyStimulus(1, 1, 0, 1, 0, 1);
    checkValue("acc idx1", decOut, 8'h02);
    applyStimulus(1, 4, 0, 1, 0, 1);
    checkValue("acc idx4", decOut, 8'h12);
    applyStimulus(1, 2, 0, 0, 0, 1);
    checkValue("plain idx2", decOut, 8'h04);
    applyStimulus(1, 1, 0, 1, 0, 1);
    checkValue("acc idx1 again", decOut, 8'h12);
    checkValue("acc final mask", accMask, 8'h12);

    // Clear plus accumulate together
    applyStimulus(1, 3, 0, 1, 1, 1);
    checkValue("clr+acc dec_out", decOut, 8'h08);
    checkValue("clr+acc mask", accMask, 8'h08);
    applyStimulus(0, 0, 0, 0, 0, 1);

    // Backpressure fills both entries
    applyStimulus(1, 2, 0, 0, 0, 0);
    applyStimulus(1, 3, 0, 0, 0, 0);
    checkValue("full in_ready", {7'd0, inReady}, 8'h00);
    checkValue("full hold", decOut, 8'h04);
    applyStimulus(1, 6, 0, 0, 0, 0);
    checkValue("full still holds", decOut, 8'h04);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkValue("drain second", decOut, 8'h08);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkValue("drained in_ready", {7'd0, inReady}, 8'h01);

    // Refill, then asynchronous reset between edges
    applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(1, 4, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    expQ.delete();
    modelMask = 8'h00;
    armed     = 1'b0;
    checkValue("async out_valid", {7'd0, outValid}, 8'h00);
    checkValue("async acc_mask", accMask, 8'h00);
    checkValue("async dec_out", decOut, 8'h00);
    checkValue("async in_ready", {7'd0, inReady}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, 5, 0, 0, 0, 1);
    applyStimulus(1, 6, 0, 1, 0, 1);
    checkValue("post-reset fresh", decOut, 8'h40);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 7),
                    $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
